// File: rtl/frame_deserializer.sv
// Frame deserializer: hunts for a sync word, reads a length header, then
// deserializes payload bytes MSB first onto a valid/ready byte interface.
// Optional CRC-8 trailer check enabled by defining FRAME_DESER_CRC8_EN.
module frame_deserializer #(
  parameter logic [15:0] SYNC_WORD    = 16'hD391,
  parameter int unsigned SYNC_LEN     = 16,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic [7:0] len_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       timeout_o,
  output logic       overrun_o,
`ifdef FRAME_DESER_CRC8_EN
  output logic       crc_ok_o,
  output logic       crc_err_o,
`endif
  output logic       busy_o
);

  localparam logic [16:0] SYNC_MASK_W = (17'd1 << SYNC_LEN) - 17'd1;
  localparam logic [15:0] SYNC_MASK   = SYNC_MASK_W[15:0];
  localparam logic [8:0]  SYNC_LEN_W  = 9'(SYNC_LEN);
  localparam logic [8:0]  SYNC_TO_W   = 9'(SYNC_TIMEOUT);

`ifdef FRAME_DESER_CRC8_EN
  typedef enum logic [2:0] {IDLE, SYNC, HEADER, PAYLOAD, CRC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, HEADER, PAYLOAD} state_t;
`endif

  state_t      state;
  logic        start_q;
  logic [14:0] sync_sr;
  logic [7:0]  sync_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  remaining;

  logic        rise;
  logic [15:0] sync_shift;
  logic [8:0]  sync_cnt_nx;
  logic        sync_hit;
  logic [7:0]  byte_nx;
  logic        new_byte;

  assign rise        = start_i & ~start_q;
  assign sync_shift  = {sync_sr, bit_i};
  assign sync_cnt_nx = {1'b0, sync_cnt} + 9'd1;
  assign sync_hit    = (sync_cnt_nx >= SYNC_LEN_W) &&
                       ((sync_shift & SYNC_MASK) == (SYNC_WORD & SYNC_MASK));
  assign byte_nx     = {shreg, bit_i};
  assign new_byte    = bit_valid_i && (state == PAYLOAD) && (bit_cnt == 3'd7);

`ifdef FRAME_DESER_CRC8_EN
  logic [7:0] crc;
  logic [7:0] crc_nx;
  // Bit-serial CRC-8, poly 0x07, MSB first
  assign crc_nx = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_i) ? 8'h07 : 8'h00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      sync_sr       <= '0;
      sync_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      remaining     <= '0;
      byte_o        <= '0;
      byte_valid_o  <= 1'b0;
      len_o         <= '0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      timeout_o     <= 1'b0;
      overrun_o     <= 1'b0;
      busy_o        <= 1'b0;
`ifdef FRAME_DESER_CRC8_EN
      crc           <= '0;
      crc_ok_o      <= 1'b0;
      crc_err_o     <= 1'b0;
`endif
    end else begin
      start_q       <= start_i;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      timeout_o     <= 1'b0;
`ifdef FRAME_DESER_CRC8_EN
      crc_ok_o      <= 1'b0;
      crc_err_o     <= 1'b0;
`endif

      // Output register: a new byte lands only if the slot is free or drains now
      if (new_byte) begin
        if (!byte_valid_o || byte_ready_i) begin
          byte_o       <= byte_nx;
          byte_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (byte_valid_o && byte_ready_i) begin
        byte_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= SYNC;
            busy_o   <= 1'b1;
            sync_sr  <= '0;
            sync_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef FRAME_DESER_CRC8_EN
            crc      <= '0;
`endif
          end
        end

        SYNC: begin
          if (bit_valid_i) begin
            sync_sr  <= sync_shift[14:0];
            sync_cnt <= sync_cnt_nx[7:0];
            if (sync_hit) begin
              state <= HEADER;
            end else if (sync_cnt_nx == SYNC_TO_W) begin
              timeout_o <= 1'b1;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end
          end
        end

        HEADER: begin
          if (bit_valid_i) begin
            shreg   <= byte_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
`ifdef FRAME_DESER_CRC8_EN
            crc     <= crc_nx;
`endif
            if (bit_cnt == 3'd7) begin
              len_o     <= byte_nx;
              remaining <= byte_nx;
              if (byte_nx == 8'd0) begin
`ifdef FRAME_DESER_CRC8_EN
                state <= CRC;
`else
                frame_end_o <= 1'b1;
                state       <= IDLE;
                busy_o      <= 1'b0;
`endif
              end else begin
                frame_start_o <= 1'b1;
                overrun_o     <= 1'b0;
                state         <= PAYLOAD;
              end
            end
          end
        end

        PAYLOAD: begin
          if (bit_valid_i) begin
            shreg   <= byte_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
`ifdef FRAME_DESER_CRC8_EN
            crc     <= crc_nx;
`endif
            if (bit_cnt == 3'd7) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
`ifdef FRAME_DESER_CRC8_EN
                state <= CRC;
`else
                frame_end_o <= 1'b1;
                state       <= IDLE;
                busy_o      <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef FRAME_DESER_CRC8_EN
        // Trailer byte is compared against the running CRC, never forwarded
        CRC: begin
          if (bit_valid_i) begin
            shreg   <= byte_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              frame_end_o <= 1'b1;
              crc_ok_o    <= (byte_nx == crc);
              crc_err_o   <= (byte_nx != crc);
              state       <= IDLE;
              busy_o      <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_deserializer.md
Name: frame_deserializer

Overview:
- Sits directly downstream of the preamble detector, whose start pulse/level is `start_i`.
- After start: hunts for a sync word, reads an 8-bit length header, then deserializes that many payload bytes, MSB first, from the demodulated bitstream.
- Delivers bytes to the packet sink over a valid/ready handshake, with frame framing strobes and error flags.

Parameters:
- SYNC_WORD, 16'hD391, sync pattern expected after the preamble, MSB received first.
- SYNC_LEN, 16, number of significant bits of SYNC_WORD (1..16; compare the low SYNC_LEN bits).
- SYNC_TIMEOUT, 64, bits allowed in SYNC before abort (must be >= SYNC_LEN, <= 255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  preamble-found indication; level or pulse, rising edge is used.
- bit_i  in  1  demodulated data bit.
- bit_valid_i  in  1  bit_i is valid this cycle.
- byte_o  out  8  deserialized payload byte.
- byte_valid_o  out  1  byte_o valid; held until accepted.
- byte_ready_i  in  1  sink accepts byte_o when byte_valid_o=1.
- len_o  out  8  length field of current/last frame.
- frame_start_o  out  1  1-cycle pulse, header accepted with length > 0.
- frame_end_o  out  1  1-cycle pulse, frame finished.
- timeout_o  out  1  1-cycle pulse, sync not found.
- overrun_o  out  1  sticky, byte dropped due to backpressure.
- busy_o  out  1  high in any state other than IDLE.
- crc_ok_o / crc_err_o  out  1  only with CRC8_EN; see Optional Feature.

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, all shift registers and counters 0, edge-detect register 0.
- start_i is registered; rise = start_i & ~start_q. Rises outside IDLE are ignored.
- Bits are consumed only on cycles with bit_valid_i=1; otherwise datapath state holds and only the handshake logic acts.
- IDLE: on rise, go to SYNC and clear the bit counter and sync shift register.
- SYNC:
  - Shift bit_i into the LSB and increment the bit counter.
  - If counter+1 >= SYNC_LEN and the shifted value matches SYNC_WORD: go to HEADER.
  - Else if counter+1 == SYNC_TIMEOUT: pulse timeout_o and go to IDLE.
- HEADER:
  - Collect 8 bits MSB first.
  - On the 8th bit, load len_o and a remaining counter with that value.
  - Length 0: pulse frame_end_o, go to IDLE.
  - Otherwise: pulse frame_start_o, clear overrun_o, go to PAYLOAD.
- PAYLOAD:
  - Collect 8 bits MSB first.
  - On the edge sampling the 8th bit, offer the byte to the output register and decrement remaining.
  - When remaining reaches 0, pulse frame_end_o on the same edge and go to IDLE.
- Output register and handshake:
  - Accept = byte_valid_o & byte_ready_i.
  - New byte with register free or accepted this cycle: load byte_o, byte_valid_o=1.
  - New byte, register full and not accepted: byte dropped, byte_o unchanged, overrun_o=1 (sticky until the next frame_start_o or reset).
  - Accept with no new byte: byte_valid_o=0 next edge.
  - byte_o and byte_valid_o are stable while byte_valid_o=1 and byte_ready_i=0.
- Latency: byte_valid_o is high in the cycle after the 8th bit is sampled, i.e. 1 clk.
- frame_end_o and the last byte's byte_valid_o rise on the same edge.
- A rise on start_i during any non-IDLE state does not restart the frame.
- Reset mid-frame aborts immediately; no frame_end_o.
- Bit counter widths: 8 bits for sync, 3 bits plus wrap for bytes, 8 bits for remaining.

Optional Feature:
- Macro: FRAME_DESER_CRC8_EN.
- With the macro:
  - A CRC-8 is kept over the length byte and all payload bytes: polynomial 0x07, init 0x00, MSB-first bitwise update, no final XOR.
  - After the last payload byte, state CRC collects one more byte (not sent to byte_o).
  - When it is complete, frame_end_o pulses together with exactly one of crc_ok_o (equal) or crc_err_o (not equal).
  - Length 0: the CRC byte is still read before frame_end_o.
- Without the macro:
  - No CRC state, no crc_ok_o/crc_err_o ports.
  - frame_end_o behaves as in Behaviour.

Test Plan:
- Nominal frame: rise, bits D391, length 0x02, 0xA5, 0x3C, byte_ready_i=1 -> frame_start_o after header; byte_o 0xA5 then 0x3C; frame_end_o with 2nd byte; len_o=0x02; overrun_o=0.
- Sync timeout: rise, then 64 bits of 0x55 pattern -> timeout_o 1-cycle pulse on the 64th bit; state IDLE; no byte_valid_o.
- Backpressure: 3-byte frame 0x11, 0x22, 0x33 with byte_ready_i=0 throughout -> byte_o holds 0x11; overrun_o=1 on the 2nd byte; then ready=1 -> 0x11 accepted once.
- Simultaneous load/accept: bit_valid_i every cycle, ready pulsed on the same cycle the 2nd byte completes -> byte_o=2nd byte, byte_valid_o stays 1, overrun_o=0.
- Length 0 and mid-frame reset: header 0x00 -> frame_end_o without frame_start_o; separately, rst asserted in PAYLOAD -> all outputs 0 asynchronously, no frame_end_o.
- CRC8_EN: length 0x01, payload 0x00, CRC byte 0x15 -> crc_ok_o with frame_end_o; same frame with CRC byte 0x14 -> crc_err_o.
